// File: rtl/led_sequencer_pkg.sv
// led_sequencer_pkg
//   Shared types and constants for the LED sequencer.
//   state_t     : controller states (CLEAR/LOAD/RUN).
//   mode_t      : pattern modes selected by the command word.
//   CMD_*       : bit positions of the command word fields.
//   CB_*_OFS    : callback field offsets, relative to bit LED_WIDTH
//                 (the LED image occupies the low LED_WIDTH bits).
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_PWM    = 2'd3
  } mode_t;

  localparam int RATE_W = 5;
  localparam int DUTY_W = 8;

  localparam int CMD_MODE_MSB = 31;
  localparam int CMD_MODE_LSB = 30;
  localparam int CMD_RATE_MSB = 28;
  localparam int CMD_RATE_LSB = 24;
  localparam int CMD_DUTY_MSB = 23;
  localparam int CMD_DUTY_LSB = 16;

  localparam int CB_RATE_OFS  = 0;
  localparam int CB_MODE_OFS  = 5;
  localparam int CB_STATE_OFS = 7;

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler
//   Free-running tick generator. Counts 0 .. 2^min(rate, PRESCALE_WIDTH) - 1
//   and pulses tick on the wrap cycle; rate = 0 ticks every cycle.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   clr   : synchronous counter clear
//   rate  : 5-bit exponent of the tick period
//   tick  : one-cycle pulse on the wrap cycle
module led_prescaler
  import led_sequencer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  logic [PRESCALE_WIDTH-1:0] cnt_r;
  logic [PRESCALE_WIDTH-1:0] wrap_val;

  // Thermometer mask of rate ones; rates beyond the counter width saturate.
  always_comb begin
    wrap_val = '0;
    for (int i = 0; i < PRESCALE_WIDTH; i++) begin
      if (i < int'(rate)) wrap_val[i] = 1'b1;
    end
  end

  assign tick = (cnt_r == wrap_val);

  always_ff @(posedge clk) begin
    if (!rst_n)          cnt_r <= '0;
    else if (clr | tick) cnt_r <= '0;
    else                 cnt_r <= cnt_r + CNT_ONE;
  end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer
//   Command-driven LED pattern generator (static / blink / rotate / PWM),
//   paced by led_prescaler, with a registered status word.
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   en_i       : load strobe, rising edge loads data_in_w
//   clr_i      : clear request (level), wins over a simultaneous load
//   data_in_w  : command {mode[31:30], rate[28:24], duty[23:16], pattern}
//   callback_o : {0, state, mode, rate, led} while running, else 0
//   led_o      : registered LED drive
//   Build option: define LED_SEQUENCER_PWM_EN to enable PWM for mode 11;
//   otherwise mode 11 behaves as STATIC and the PWM counter/duty register
//   are not built.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | LEDs off, waiting for a load event
//   LOAD  | one cycle: apply initial pattern, zero prescaler/PWM counter
//   RUN   | pattern evolves on each prescaler tick
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int LED_WIDTH      = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int CALLBACK_WIDTH = 32,
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [DATA_WIDTH-1:0]     data_in_w,
  output logic [CALLBACK_WIDTH-1:0] callback_o,
  output logic [LED_WIDTH-1:0]      led_o
);

  logic en_r, en_d, clr_r;
  logic load_evt, capture, tick, presc_clr;

  state_t state_r, state_nxt;
  mode_t  mode_r;
  logic [RATE_W-1:0]         rate_r;
  logic [LED_WIDTH-1:0]      pattern_r;
  logic [LED_WIDTH-1:0]      led_r, led_nxt;
  logic [CALLBACK_WIDTH-1:0] cb_r, cb_nxt;

`ifdef LED_SEQUENCER_PWM_EN
  logic [DUTY_W-1:0] duty_r;
  logic [7:0]        pwm_cnt_r, pwm_nxt, pwm_inc;
`endif

  // Not every command bit is decoded in every build.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^data_in_w;

  assign load_evt  = en_r & ~en_d & ~clr_r;
  assign capture   = load_evt & ((state_r == CLEAR) | (state_r == RUN));
  assign presc_clr = clr_r | (state_r != RUN);

  led_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .rate  (rate_r),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= CLEAR;
    else        state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    if (clr_r) begin
      state_nxt = CLEAR;
    end else begin
      case (state_r)
        CLEAR:   if (load_evt) state_nxt = LOAD;
        LOAD:    state_nxt = RUN;
        RUN:     if (load_evt) state_nxt = LOAD;
        default: state_nxt = CLEAR;
      endcase
    end
  end

  always_comb begin
    led_nxt = led_r;
`ifdef LED_SEQUENCER_PWM_EN
    pwm_inc = pwm_cnt_r + 8'd1;
    pwm_nxt = pwm_cnt_r;
`endif
    if (clr_r) begin
      led_nxt = '0;
`ifdef LED_SEQUENCER_PWM_EN
      pwm_nxt = '0;
`endif
    end else begin
      case (state_r)
        CLEAR: begin
          led_nxt = '0;
`ifdef LED_SEQUENCER_PWM_EN
          pwm_nxt = '0;
`endif
        end
        LOAD: begin
          led_nxt = pattern_r;
`ifdef LED_SEQUENCER_PWM_EN
          pwm_nxt = '0;
          if ((mode_r == MODE_PWM) && (duty_r == 8'd0)) led_nxt = '0;
`endif
        end
        RUN: begin
          // A reload holds the current LEDs until LOAD applies the new pattern.
          if (tick && !load_evt) begin
            case (mode_r)
              MODE_BLINK:  led_nxt = led_r ^ pattern_r;
              MODE_ROTATE: led_nxt = {led_r[LED_WIDTH-2:0], led_r[LED_WIDTH-1]};
`ifdef LED_SEQUENCER_PWM_EN
              MODE_PWM: begin
                pwm_nxt = pwm_inc;
                led_nxt = (pwm_inc < duty_r) ? pattern_r : '0;
              end
`endif
              default: ;
            endcase
          end
        end
        default: led_nxt = '0;
      endcase
    end
  end

  always_comb begin
    cb_nxt = '0;
    if (state_r == RUN) begin
      cb_nxt[LED_WIDTH-1:0]                     = led_r;
      cb_nxt[LED_WIDTH+CB_RATE_OFS +: RATE_W]   = rate_r;
      cb_nxt[LED_WIDTH+CB_MODE_OFS +: 2]        = mode_r;
      cb_nxt[LED_WIDTH+CB_STATE_OFS +: 2]       = state_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_r      <= 1'b0;
      en_d      <= 1'b0;
      clr_r     <= 1'b0;
      mode_r    <= MODE_STATIC;
      rate_r    <= '0;
      pattern_r <= '0;
      led_r     <= '0;
      cb_r      <= '0;
`ifdef LED_SEQUENCER_PWM_EN
      duty_r    <= '0;
      pwm_cnt_r <= '0;
`endif
    end else begin
      en_r  <= en_i;
      en_d  <= en_r;
      clr_r <= clr_i;
      led_r <= led_nxt;
      cb_r  <= cb_nxt;
      if (capture) begin
        mode_r    <= mode_t'(data_in_w[CMD_MODE_MSB:CMD_MODE_LSB]);
        rate_r    <= data_in_w[CMD_RATE_MSB:CMD_RATE_LSB];
        pattern_r <= data_in_w[LED_WIDTH-1:0];
`ifdef LED_SEQUENCER_PWM_EN
        duty_r    <= data_in_w[CMD_DUTY_MSB:CMD_DUTY_LSB];
`endif
      end
`ifdef LED_SEQUENCER_PWM_EN
      pwm_cnt_r <= pwm_nxt;
`endif
    end
  end

  assign led_o      = led_r;
  assign callback_o = cb_r;

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [31:0] data_in_w = '0;
  logic [31:0] callback_o;
  logic [7:0]  led_o;

  led_sequencer #(
    .LED_WIDTH      (8),
    .DATA_WIDTH     (32),
    .CALLBACK_WIDTH (32),
    .PRESCALE_WIDTH (24)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .data_in_w  (data_in_w),
    .callback_o (callback_o),
    .led_o      (led_o)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_cb;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] cmd(input logic [1:0] md, input logic [4:0] r,
                                      input logic [7:0] d, input logic [7:0] p);
    return {md, 1'b0, r, d, 8'h00, p};
  endfunction

  function automatic logic [31:0] cbv(input logic [1:0] st, input logic [1:0] md,
                                      input logic [4:0] r, input logic [7:0] l);
    return {15'd0, st, md, r, l};
  endfunction

  task automatic push_led(input int c, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.is_cb = 1'b0; e.val = {24'd0, v}; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic push_cb(input int c, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.is_cb = 1'b1; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compares every queued expectation that falls due this cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = sb[i].is_cb ? callback_o : {24'd0, led_o};
        checks++;
        if (sb[i].cyc != cyc) begin
          errors++;
          $display("FAIL %s: check for cycle %0d not reached until cycle %0d", sb[i].name, sb[i].cyc, cyc);
        end else if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  // Drives one-cycle en_i pulse; returns the cycle at which it was driven.
  task automatic do_load(input logic [31:0] w, output int t);
    @(negedge clk);
    t = cyc;
    data_in_w = w;
    en_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
  endtask

  initial begin
    int          t;
    int          s;
    int          u;
    logic [7:0]  v;
    logic [7:0]  ev;
    int          pk[7] = '{0, 63, 64, 255, 256, 319, 320};

    push_led(2, 8'h00, "reset_led");
    push_cb (2, 32'h0, "reset_cb");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_led(6, 8'h00, "idle_led");
    push_cb (6, 32'h0, "idle_cb");

    // STATIC, R=3, P=A5
    do_load(cmd(2'd0, 5'd3, 8'd0, 8'hA5), t);
    push_led(t + 2, 8'h00, "static_before");
    push_led(t + 3, 8'hA5, "static_led");
    push_cb (t + 3, 32'h0, "static_cb_lag");
    push_cb (t + 4, cbv(2'b10, 2'b00, 5'd3, 8'hA5), "static_cb");
    push_led(t + 12, 8'hA5, "static_hold");
    repeat (12) @(negedge clk);

    // BLINK, R=2, P=0F, loaded straight from RUN
    do_load(cmd(2'd1, 5'd2, 8'd0, 8'h0F), t);
    push_led(t + 2,  8'hA5, "blink_no_gap");
    push_led(t + 3,  8'h0F, "blink_init");
    push_led(t + 6,  8'h0F, "blink_pre_tick");
    push_led(t + 7,  8'h00, "blink_tick1");
    push_led(t + 10, 8'h00, "blink_hold");
    push_led(t + 11, 8'h0F, "blink_tick2");
    push_led(t + 15, 8'h00, "blink_tick3");
    repeat (15) @(negedge clk);

    // ROTATE, R=0, P=81: one step per cycle, wraps after 8
    do_load(cmd(2'd2, 5'd0, 8'd0, 8'h81), t);
    v = 8'h81;
    for (int k = 0; k <= 8; k++) begin
      push_led(t + 3 + k, v, "rotate");
      v = {v[6:0], v[7]};
    end
    repeat (10) @(negedge clk);

    // en_i held for 10 cycles, word at E1 is the one that loads
    @(negedge clk);
    t = cyc;
    push_led(t + 3,  8'h55, "held_en_load");
    push_cb (t + 4,  cbv(2'b10, 2'b00, 5'd1, 8'h55), "held_en_cb");
    push_led(t + 8,  8'h55, "held_en_once");
    push_led(t + 16, 8'h55, "held_en_after");
    en_i = 1'b1;
    data_in_w = cmd(2'd0, 5'd0, 8'd0, 8'h11);
    @(negedge clk);
    data_in_w = cmd(2'd0, 5'd1, 8'd0, 8'h55);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      data_in_w = cmd(2'd1, 5'd0, 8'd0, 8'hFF);
    end
    @(negedge clk);
    en_i = 1'b0;
    repeat (7) @(negedge clk);

    // clr_i and en_i together: clear wins
    @(negedge clk);
    s = cyc;
    push_cb (s + 2, cbv(2'b10, 2'b00, 5'd1, 8'h55), "clr_cb_lag");
    push_led(s + 2, 8'h00, "clr_led");
    push_cb (s + 3, 32'h0, "clr_cb");
    push_led(s + 8, 8'h00, "clr_no_load");
    push_cb (s + 8, 32'h0, "clr_cb_idle");
    en_i = 1'b1;
    clr_i = 1'b1;
    data_in_w = cmd(2'd1, 5'd0, 8'd0, 8'hFF);
    @(negedge clk);
    en_i = 1'b0;
    clr_i = 1'b0;
    repeat (8) @(negedge clk);

    // Mode 11, D=64, R=0, P=FF
    do_load(cmd(2'd3, 5'd0, 8'd64, 8'hFF), t);
    foreach (pk[i]) begin
`ifdef LED_SEQUENCER_PWM_EN
      ev = ((pk[i] % 256) < 64) ? 8'hFF : 8'h00;
`else
      ev = 8'hFF;
`endif
      push_led(t + 3 + pk[i], ev, "mode3_d64");
    end
    push_cb(t + 4, cbv(2'b10, 2'b11, 5'd0, 8'hFF), "mode3_cb");
    repeat (325) @(negedge clk);

    // Mode 11, D=0
    do_load(cmd(2'd3, 5'd0, 8'd0, 8'hFF), t);
`ifdef LED_SEQUENCER_PWM_EN
    ev = 8'h00;
`else
    ev = 8'hFF;
`endif
    push_led(t + 3,   ev, "mode3_d0_init");
    push_led(t + 4,   ev, "mode3_d0_run");
    push_led(t + 100, ev, "mode3_d0_late");
    repeat (100) @(negedge clk);

    // Reload BLINK -> STATIC 3C with no zero cycle in between
    do_load(cmd(2'd1, 5'd3, 8'd0, 8'hF0), u);
    push_led(u + 3, 8'hF0, "reload_blink_init");
    repeat (3) @(negedge clk);
    do_load(cmd(2'd0, 5'd0, 8'd0, 8'h3C), t);
    push_led(t + 2, 8'hF0, "reload_no_zero");
    push_led(t + 3, 8'h3C, "reload_led");
    push_led(t + 4, 8'h3C, "reload_hold");
    push_cb (t + 4, cbv(2'b10, 2'b00, 5'd0, 8'h3C), "reload_cb");
    repeat (5) @(negedge clk);

    // Reset mid-RUN with en_i high
    @(negedge clk);
    t = cyc;
    push_led(t + 1, 8'h00, "rst_run_led");
    push_cb (t + 1, 32'h0, "rst_run_cb");
    push_led(t + 4, 8'h00, "rst_after_led");
    push_cb (t + 4, 32'h0, "rst_after_cb");
    rst_n = 1'b0;
    en_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    en_i = 1'b0;

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
